// File: rtl/countdown.sv
// rtl/countdown.sv - loadable mm:ss countdown timer with timed, blinking alarm
module countdown #(
    parameter int MAX_MIN    = 99,
    parameter int ALARM_SECS = 10
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       sec,
    input  logic       load,
    input  logic [6:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [6:0] r_min,
    output logic [5:0] r_sec,
    output logic       running,
    output logic       done,
    output logic       alarm,
    output logic       blink
);

    localparam int              CW         = (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;
    localparam logic [6:0]      MAX_MIN_V  = 7'(MAX_MIN);
    localparam logic [CW-1:0]   ALARM_INIT = CW'(ALARM_SECS);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READY,
        S_RUN,
        S_ALARM
    } state_t;

    state_t          state, state_n;
    logic [6:0]      min_n;
    logic [5:0]      sec_n;
    logic            done_n;
    logic            blink_n;
    logic [CW-1:0]   alarm_cnt, cnt_n;
    logic [6:0]      clamp_min;
    logic [5:0]      clamp_sec;
    logic            last_tick;
    logic            load_ok;
    logic            stop_ok;
    logic            start_ok;

    assign clamp_min = (load_min > MAX_MIN_V) ? MAX_MIN_V : load_min;
    assign clamp_sec = (load_sec > 6'd59) ? 6'd59 : load_sec;
    assign last_tick = (r_min == 7'd0) && (r_sec == 6'd1);

    // A command only claims the cycle when it is meaningful in the current
    // state; an ignored command lets lower-priority ones (and sec) through.
    assign load_ok  = load && (state != S_RUN);
    assign stop_ok  = stop && ((state == S_RUN) || (state == S_ALARM));
    assign start_ok = start && ((state == S_READY) || (state == S_ALARM));

    always_comb begin
        state_n = state;
        min_n   = r_min;
        sec_n   = r_sec;
        done_n  = 1'b0;
        blink_n = blink;
        cnt_n   = alarm_cnt;

        if (clear) begin
            state_n = S_IDLE;
            min_n   = 7'd0;
            sec_n   = 6'd0;
            blink_n = 1'b0;
            cnt_n   = '0;
        end else if (load_ok) begin
            min_n   = clamp_min;
            sec_n   = clamp_sec;
            blink_n = 1'b0;
            cnt_n   = '0;
            state_n = ((clamp_min == 7'd0) && (clamp_sec == 6'd0)) ? S_IDLE : S_READY;
        end else if (stop_ok) begin
            if (state == S_RUN) begin
                state_n = S_READY;
            end else begin
                state_n = S_IDLE;
                blink_n = 1'b0;
                cnt_n   = '0;
            end
        end else if (start_ok) begin
            if (state == S_READY) begin
                state_n = S_RUN;
            end else begin
                state_n = S_IDLE;
                blink_n = 1'b0;
                cnt_n   = '0;
            end
        end else if (sec) begin
            case (state)
                S_RUN: begin
                    if (last_tick) begin
                        min_n   = 7'd0;
                        sec_n   = 6'd0;
                        state_n = S_ALARM;
                        done_n  = 1'b1;
                        blink_n = 1'b1;
                        cnt_n   = ALARM_INIT;
                    end else if (r_sec != 6'd0) begin
                        sec_n = r_sec - 6'd1;
                    end else begin
                        sec_n = 6'd59;
                        min_n = r_min - 7'd1;
                    end
                end
                S_ALARM: begin
                    blink_n = ~blink;
                    if (ALARM_SECS != 0) begin
                        if (alarm_cnt == CNT_ONE) begin
                            state_n = S_IDLE;
                            blink_n = 1'b0;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = alarm_cnt - CNT_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state     <= S_IDLE;
            r_min     <= 7'd0;
            r_sec     <= 6'd0;
            running   <= 1'b0;
            done      <= 1'b0;
            alarm     <= 1'b0;
            blink     <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            state     <= state_n;
            r_min     <= min_n;
            r_sec     <= sec_n;
            running   <= (state_n == S_RUN);
            done      <= done_n;
            alarm     <= (state_n == S_ALARM);
            blink     <= blink_n;
            alarm_cnt <= cnt_n;
        end
    end

endmodule

// File: doc/countdown.md
# countdown

Loadable minutes:seconds countdown timer driven by the one-cycle `sec` strobe of the seconds divider; it consumes that tick rather than producing it. It sits between the user-input logic (load/start/stop/clear) and the display/alarm drivers. It holds a paused value, counts down once per strobe while running, and raises a timed alarm with a blink output on reaching 00:00.

## Interface
- `MAX_MIN`, default 99: largest loadable minute value; must be ≤ 127.
- `ALARM_SECS`, default 10: alarm duration in `sec` ticks; 0 means the alarm holds until acknowledged.

Ports:
- `mclk`  in  1  single clock, all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `sec`  in  1  one-`mclk` tick, once per second.
- `load`  in  1  pulse: capture `load_min`/`load_sec`.
- `load_min`  in  7  minutes to load.
- `load_sec`  in  6  seconds to load.
- `start`  in  1  pulse: run, or acknowledge the alarm.
- `stop`  in  1  pulse: pause, or acknowledge the alarm.
- `clear`  in  1  pulse: abort to 00:00.
- `r_min`  out  7  current minutes.
- `r_sec`  out  6  current seconds, 0..59.
- `running`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse on expiry.
- `alarm`  out  1  high in ALARM.
- `blink`  out  1  alarm flasher; 0 outside ALARM.

## Operation
- States:
  - IDLE: value 00:00, nothing pending.
  - READY: nonzero value, paused.
  - RUN: counting down.
  - ALARM: expired.
- Per-cycle priority: `reset` > `clear` > `load` > `stop` > `start` > `sec`. At most one action is taken per cycle.
- `clear`: any state → IDLE, value 00:00, alarm cleared.
- `load`:
  - Accepted in IDLE, READY and ALARM (in ALARM it cancels the alarm). Ignored in RUN.
  - Clamps: `load_sec` > 59 → 59; `load_min` > MAX_MIN → MAX_MIN.
  - A clamped value of 00:00 goes to IDLE; any other value goes to READY.
- `stop`:
  - RUN → READY, value held.
  - ALARM → IDLE (acknowledge).
  - Ignored in other states.
- `start`:
  - READY → RUN.
  - ALARM → IDLE (acknowledge).
  - Ignored in IDLE and RUN.
- `sec` in RUN:
  - If `r_sec` > 0, `r_sec`−1.
  - Otherwise `r_sec` ← 59 and `r_min`−1.
  - If the value before the tick was 00:01, the value becomes 00:00 and the state → ALARM. That same edge asserts `done` for exactly one cycle, sets `blink`=1 and loads `alarm_cnt` ← ALARM_SECS.
- `sec` in ALARM:
  - `blink` toggles.
  - If ALARM_SECS ≠ 0, `alarm_cnt`−1; when `alarm_cnt` = 1 before the tick, → IDLE with `blink`=0.
  - With ALARM_SECS = 0 the alarm never times out; only `start`, `stop`, `load` or `clear` leave ALARM.
- `sec` in IDLE or READY: no effect.
- `r_min` never underflows: a `sec` tick with a value of 00:00 in RUN cannot occur by construction, because entry to RUN requires a nonzero value.
- `alarm_cnt` is internal, width `$clog2(ALARM_SECS+1)` (minimum 1).

## Timing
- All outputs are registered.
- Reset values (after `reset`): state IDLE, `r_min`=0, `r_sec`=0, `running`=0, `done`=0, `alarm`=0, `blink`=0, `alarm_cnt`=0.
- Latencies:
  - `load`/`start`/`stop`/`clear` take effect on the edge where they are sampled; outputs reflect the change the following cycle.
  - A `sec` tick updates `r_min`/`r_sec` on the edge where it is sampled.
  - `done` and `alarm` rise on the same edge as the final decrement to 00:00.
- `start` coincident with `sec` in READY: enters RUN; that tick is not consumed. The first decrement occurs on the next `sec`.
- `stop` coincident with `sec` in RUN: pauses with no decrement.
- `load` coincident with `sec` in ALARM: the load wins; no blink toggle.
- Back-to-back `sec` ticks on consecutive cycles are legal and each one decrements.
- `reset` or `clear` mid-RUN or mid-ALARM: the next cycle shows IDLE with all outputs at their reset values.

## Test plan
- Reset, then `load` 01:00, `start`, then 3 `sec` ticks → 00:57, `running`=1. `stop`, then 2 ticks → value stays 00:57, `running`=0.
- `load` 00:02, `start`, then 2 ticks → after the 2nd tick: 00:00, `done` high for exactly 1 cycle, `alarm`=1, `blink`=1. With ALARM_SECS=3 and 3 further ticks: `blink` 0,1 then IDLE with `alarm`=0, `blink`=0.
- `load` `load_min`=120 and `load_sec`=63 with MAX_MIN=99 → 99:59, READY. `load` 00:00 → IDLE; a subsequent `start` is ignored and `running` stays 0.
- Minute borrow: `load` 02:00, `start`, 1 tick → 01:59. `load` asserted while running is ignored and the value stays 01:59.
- Simultaneity:
  - `start`+`sec` in READY at 00:05 → RUN at 00:05.
  - `stop`+`sec` in RUN at 00:05 → READY at 00:05.
  - `clear`+`load` → IDLE at 00:00.
- ALARM_SECS=0: expire, then 100 ticks → `alarm` still 1 with `blink` alternating. `stop` → IDLE, `alarm`=0. Repeat the expiry and instead assert `reset` mid-alarm → all outputs 0.
